sum_nb_serial: RTL
==================

SUM_NB_SERIAL -- requirements
Module: sum_nb_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits; WIDTH SHALL be a multiple of DIGIT.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per clock cycle; STEPS = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = add xi+yi, 1 = subtract xi-yi.
REQ-007 SHALL have port xi  input  WIDTH  operand A, two's complement or unsigned.
REQ-008 SHALL have port yi  input  WIDTH  operand B.
REQ-009 SHALL have port busy  output  1  high while digits are being processed.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port zi  output  WIDTH  result.
REQ-012 SHALL have port co  output  1  carry out of MSB (subtract: 1 = no borrow).
REQ-013 SHALL have port ov  output  1  signed overflow, carry-into-MSB XOR carry-out.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE with start=1 at a rising edge SHALL capture xi, yi (yi inverted when mode=1), set carry=mode, clear digit counter, enter RUN.
REQ-016 Each RUN edge SHALL add digit cnt (bits cnt*DIGIT+DIGIT-1 : cnt*DIGIT) with running carry, store that result digit, update carry, increment cnt.
REQ-017 After the edge processing digit STEPS-1, FSM SHALL enter DONE; total latency capture edge to done high = STEPS cycles.
REQ-018 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE; DONE SHALL return to IDLE on the next edge.
REQ-019 zi, co, ov SHALL update only on entry to DONE and hold until the next entry to DONE.
REQ-020 start in RUN or DONE SHALL be ignored (not queued); xi/yi/mode changes after capture SHALL not affect the result.
REQ-021 ov SHALL use carry into bit WIDTH-1, computed inside the final digit.
REQ-022 DIGIT = WIDTH SHALL give STEPS=1, i.e. done one cycle after capture.
REQ-023 Back-to-back: start held high SHALL begin a new operation on the edge after DONE (IDLE), giving one result per STEPS+2 cycles.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, carry=0, busy=0, done=0, zi=0, co=0, ov=0.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; outputs read 0.
REQ-026 First start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-027 Shared package sum_pkg SHALL hold FSM state encoding and MODE_ADD/MODE_SUB constants.
REQ-028 One sub-module sum_digit (parametrised DIGIT-bit combinational adder: x, y, ci -> z, co, c_msb) SHALL be instantiated once.
REQ-029 Operand shift/index logic, counter, FSM and result register SHALL reside in sum_nb_serial.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-030 add 0xFFFF+0x0001, start one cycle -> done 4 cycles after capture, zi=0x0000, co=1, ov=0; busy high exactly 4 cycles.
REQ-031 add 0x7FFF+0x0001 -> zi=0x8000, co=0, ov=1; sub 0x0005-0x0007 -> zi=0xFFFE, co=0, ov=0; sub 0x8000-0x0001 -> zi=0x7FFF, co=1, ov=1.
REQ-032 start pulsed again during RUN with different operands -> ignored, single done, first result only.
REQ-033 rst_n low mid-RUN (after 2 digits) -> busy=0, done never pulses, zi=0; next start completes correctly.
REQ-034 WIDTH=4, DIGIT=4: exhaustive xi,yi 0..15, both modes, vs reference model -> zi,co,ov match; done one cycle after each capture.
REQ-035 start held high for 3 operations -> done pulses spaced STEPS+2=6 cycles apart, each result correct.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encoding and mode constants.
package sum_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sum_digit.sv
// DIGIT-bit combinational adder slice with carry out and carry into its top bit.
module sum_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] z,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] sum;

  assign sum   = {1'b0, x} + {1'b0, y} + (DIGIT + 1)'(ci);
  assign z     = sum[DIGIT-1:0];
  assign co    = sum[DIGIT];
  // Sum bit = x ^ y ^ carry-in, so the carry into the top bit falls out directly.
  assign c_msb = z[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/sum_nb_serial.sv
// Digit-serial add/subtract: processes DIGIT bits per cycle, WIDTH/DIGIT cycles per operation.
module sum_nb_serial
  import sum_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] xi,
  input  logic [WIDTH-1:0] yi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zi,
  output logic             co,
  output logic             ov
);

  localparam int unsigned Steps = WIDTH / DIGIT;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] x_q, y_q, acc_q;
  logic             busy_q, done_q, co_q, ov_q;
  logic [WIDTH-1:0] zi_q;

  logic [DIGIT-1:0] dig_z;
  logic             dig_co, dig_cmsb;
  logic [WIDTH-1:0] acc_next;
  logic             last;

  sum_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .x    (x_q[DIGIT-1:0]),
    .y    (y_q[DIGIT-1:0]),
    .ci   (carry_q),
    .z    (dig_z),
    .co   (dig_co),
    .c_msb(dig_cmsb)
  );

  // Operands shift right one digit per step; result digits enter from the top.
  always_comb begin
    acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_z) << (WIDTH - DIGIT));
    last     = (cnt_q == CntW'(Steps - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zi_q    <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            x_q     <= xi;
            y_q     <= (mode == MODE_SUB) ? ~yi : yi;
            carry_q <= mode;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          x_q     <= x_q >> DIGIT;
          y_q     <= y_q >> DIGIT;
          acc_q   <= acc_next;
          carry_q <= dig_co;
          cnt_q   <= cnt_q + CntW'(1);
          if (last) begin
            zi_q    <= acc_next;
            co_q    <= dig_co;
            ov_q    <= dig_co ^ dig_cmsb;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign zi   = zi_q;
  assign co   = co_q;
  assign ov   = ov_q;

endmodule
